datapath: RTL and testbench



---
 rtl/datapath_pkg.sv | 45 ++++
 rtl/datapath_alu.sv | 61 ++++++
 rtl/datapath.sv | 164 ++++++++++++++++
 tb/tb_datapath.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the bus datapath: ALU op encoding, strobe positions and
// observation-stream slot offsets. The divider is gated by DATAPATH_DIV_EN.
package datapath_pkg;

    localparam int N_OPS = 13;

    // Strobe bit positions; a lower index wins when several strobes are set.
    localparam int STB_INCPC  = 0;
    localparam int STB_ADD    = 1;
    localparam int STB_SUB    = 2;
    localparam int STB_MUL    = 3;
    localparam int STB_DIV    = 4;
    localparam int STB_SHR    = 5;
    localparam int STB_SHL    = 6;
    localparam int STB_ROR    = 7;
    localparam int STB_ROL    = 8;
    localparam int STB_AND    = 9;
    localparam int STB_OR     = 10;
    localparam int STB_NEGATE = 11;
    localparam int STB_NOT    = 12;

    typedef enum logic [3:0] {
        OP_NONE, OP_INCPC, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR,
        OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR, OP_NEGATE, OP_NOT
    } alu_op_e;

    // Slot offsets after the GPRs: SLOT_PC = REGISTERS + SLOT_PC_OFF, etc.
    localparam int SLOT_PC_OFF  = 0;
    localparam int SLOT_IR_OFF  = 1;
    localparam int SLOT_RY_OFF  = 2;
    localparam int SLOT_MAR_OFF = 3;
    localparam int SLOT_HI_OFF  = 4;
    localparam int SLOT_LO_OFF  = 5;
    localparam int SLOT_MDR_OFF = 6;

    function automatic alu_op_e encode_op(input logic [N_OPS-1:0] stb);
        alu_op_e op;
        op = OP_NONE;
        for (int i = N_OPS - 1; i >= 0; i--) begin
            if (stb[i]) op = alu_op_e'(4'(i + 1));
        end
        return op;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = RY, B = bus, double-width result.
// Signed divider present only when DATAPATH_DIV_EN is defined.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    input  logic [N_OPS-1:0]  op_stb,
    output logic [2*BITS-1:0] result
);

    localparam int SH_W = $clog2(BITS);

    alu_op_e          op;
    logic [SH_W-1:0]  amt;
    logic [2*BITS-1:0] a_ext;
    logic [2*BITS-1:0] b_ext;
    logic [2*BITS-1:0] product;

    assign op      = encode_op(op_stb);
    assign amt     = b[SH_W-1:0];
    assign a_ext   = {{BITS{a[BITS-1]}}, a};
    assign b_ext   = {{BITS{b[BITS-1]}}, b};
    // Low 2*BITS bits of the sign-extended product equal the signed product.
    assign product = a_ext * b_ext;

`ifdef DATAPATH_DIV_EN
    logic signed [BITS-1:0] quo;
    logic signed [BITS-1:0] rem;
    assign quo = $signed(a) / $signed(b);
    assign rem = $signed(a) % $signed(b);
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_INCPC:  result[BITS-1:0] = b + 1'b1;
            OP_ADD:    result[BITS-1:0] = a + b;
            OP_SUB:    result[BITS-1:0] = a - b;
            OP_MUL:    result = product;
`ifdef DATAPATH_DIV_EN
            OP_DIV: begin
                if (b == '0) result = {a, {BITS{1'b1}}};
                else         result = {rem, quo};
            end
`endif
            OP_SHR:    result[BITS-1:0] = a >> amt;
            OP_SHL:    result[BITS-1:0] = a << amt;
            OP_ROR:    result[BITS-1:0] = (a >> amt) | (a << (BITS - int'(amt)));
            OP_ROL:    result[BITS-1:0] = (a << amt) | (a >> (BITS - int'(amt)));
            OP_AND:    result[BITS-1:0] = a & b;
            OP_OR:     result[BITS-1:0] = a | b;
            OP_NEGATE: result[BITS-1:0] = -b;
            OP_NOT:    result[BITS-1:0] = ~b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Bus-based CPU datapath: registers, priority bus mux and ALU, driven by
// external strobes. Optional divider via DATAPATH_DIV_EN.
module datapath
    import datapath_pkg::*;
#(
    parameter int BITS          = 64,
    parameter int REGISTERS     = 16,
    parameter int TOT_REGISTERS = REGISTERS + 7
) (
    input  logic                          reset,
    input  logic                          Clock,
    input  logic [REGISTERS-1:0]          GPRin,
    input  logic                          PCin,
    input  logic                          IRin,
    input  logic                          RYin,
    input  logic                          RZin,
    input  logic                          MARin,
    input  logic                          HIin,
    input  logic                          LOin,
    input  logic                          MDRin,
    input  logic                          Read,
    input  logic                          MDRout,
    input  logic                          LOout,
    input  logic                          HIout,
    input  logic                          Zhighout,
    input  logic                          Zlowout,
    input  logic                          PCout,
    input  logic [REGISTERS-1:0]          GPRout,
    input  logic                          ADD,
    input  logic                          SUB,
    input  logic                          MUL,
    input  logic                          DIV,
    input  logic                          SHR,
    input  logic                          SHL,
    input  logic                          ROR,
    input  logic                          ROL,
    input  logic                          AND,
    input  logic                          OR,
    input  logic                          NEGATE,
    input  logic                          NOT,
    input  logic                          IncPC,
    input  logic [BITS-1:0]               Mdatain,
    output logic [BITS*TOT_REGISTERS-1:0] regSelectStream,
    output logic [BITS-1:0]               bus,
    output logic [BITS-1:0]               MARVal,
    output logic [BITS-1:0]               IRVal,
    output logic [2*BITS-1:0]             RZVal,
    output logic [BITS-1:0]               LOVal,
    output logic [BITS-1:0]               HIVal
);

    localparam int SLOT_PC  = REGISTERS + SLOT_PC_OFF;
    localparam int SLOT_IR  = REGISTERS + SLOT_IR_OFF;
    localparam int SLOT_RY  = REGISTERS + SLOT_RY_OFF;
    localparam int SLOT_MAR = REGISTERS + SLOT_MAR_OFF;
    localparam int SLOT_HI  = REGISTERS + SLOT_HI_OFF;
    localparam int SLOT_LO  = REGISTERS + SLOT_LO_OFF;
    localparam int SLOT_MDR = REGISTERS + SLOT_MDR_OFF;

    logic [BITS-1:0]   gpr_q [REGISTERS];
    logic [BITS-1:0]   gpr_d [REGISTERS];
    logic [BITS-1:0]   pc_q, pc_d, ir_q, ir_d, ry_q, ry_d, mar_q, mar_d;
    logic [BITS-1:0]   hi_q, hi_d, lo_q, lo_d, mdr_q, mdr_d;
    logic [2*BITS-1:0] rz_q, rz_d;
    logic [2*BITS-1:0] alu_result;
    logic [N_OPS-1:0]  op_stb;

    // Lowest-priority sources are written first so higher ones overwrite them.
    always_comb begin
        bus = '0;
        if (Zlowout)  bus = rz_q[BITS-1:0];
        if (Zhighout) bus = rz_q[2*BITS-1:BITS];
        if (LOout)    bus = lo_q;
        if (HIout)    bus = hi_q;
        if (MDRout)   bus = mdr_q;
        if (PCout)    bus = pc_q;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if (GPRout[i]) bus = gpr_q[i];
        end
    end

    always_comb begin
        op_stb             = '0;
        op_stb[STB_INCPC]  = IncPC;
        op_stb[STB_ADD]    = ADD;
        op_stb[STB_SUB]    = SUB;
        op_stb[STB_MUL]    = MUL;
        op_stb[STB_DIV]    = DIV;
        op_stb[STB_SHR]    = SHR;
        op_stb[STB_SHL]    = SHL;
        op_stb[STB_ROR]    = ROR;
        op_stb[STB_ROL]    = ROL;
        op_stb[STB_AND]    = AND;
        op_stb[STB_OR]     = OR;
        op_stb[STB_NEGATE] = NEGATE;
        op_stb[STB_NOT]    = NOT;
    end

    datapath_alu #(.BITS(BITS)) u_alu (
        .a      (ry_q),
        .b      (bus),
        .op_stb (op_stb),
        .result (alu_result)
    );

    always_comb begin
        for (int i = 0; i < REGISTERS; i++) begin
            gpr_d[i] = GPRin[i] ? bus : gpr_q[i];
        end
        pc_d  = PCin  ? bus : pc_q;
        ir_d  = IRin  ? bus : ir_q;
        ry_d  = RYin  ? bus : ry_q;
        mar_d = MARin ? bus : mar_q;
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        rz_d  = RZin  ? alu_result : rz_q;
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            ry_q  <= '0;
            mar_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mdr_q <= '0;
            rz_q  <= '0;
        end else begin
            for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= gpr_d[i];
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            ry_q  <= ry_d;
            mar_q <= mar_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            mdr_q <= mdr_d;
            rz_q  <= rz_d;
        end
    end

    always_comb begin
        regSelectStream = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            regSelectStream[k*BITS +: BITS] = gpr_q[k];
        end
        regSelectStream[SLOT_PC*BITS  +: BITS] = pc_q;
        regSelectStream[SLOT_IR*BITS  +: BITS] = ir_q;
        regSelectStream[SLOT_RY*BITS  +: BITS] = ry_q;
        regSelectStream[SLOT_MAR*BITS +: BITS] = mar_q;
        regSelectStream[SLOT_HI*BITS  +: BITS] = hi_q;
        regSelectStream[SLOT_LO*BITS  +: BITS] = lo_q;
        regSelectStream[SLOT_MDR*BITS +: BITS] = mdr_q;
    end

    assign MARVal = mar_q;
    assign IRVal  = ir_q;
    assign RZVal  = rz_q;
    assign LOVal  = lo_q;
    assign HIVal  = hi_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized ops
// checked against a behavioural register/ALU model.
module tb_datapath;

    localparam int BITS = 64;
    localparam int NREG = 16;
    localparam int TOT  = NREG + 7;

    logic             reset, Clock;
    logic [NREG-1:0]  GPRin, GPRout;
    logic             PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
    logic             MDRout, LOout, HIout, Zhighout, Zlowout, PCout;
    logic             ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    logic [BITS-1:0]  Mdatain;
    logic [BITS*TOT-1:0] regSelectStream;
    logic [BITS-1:0]  bus, MARVal, IRVal, LOVal, HIVal;
    logic [2*BITS-1:0] RZVal;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [63:0]  m_gpr [NREG];
    logic [63:0]  m_pc, m_ir, m_ry, m_mar, m_hi, m_lo, m_mdr;
    logic [127:0] m_rz;

    datapath #(.BITS(BITS), .REGISTERS(NREG), .TOT_REGISTERS(TOT)) dut (
        .reset(reset), .Clock(Clock), .GPRin(GPRin), .PCin(PCin), .IRin(IRin),
        .RYin(RYin), .RZin(RZin), .MARin(MARin), .HIin(HIin), .LOin(LOin),
        .MDRin(MDRin), .Read(Read), .MDRout(MDRout), .LOout(LOout), .HIout(HIout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .GPRout(GPRout),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .IncPC(IncPC), .Mdatain(Mdatain), .regSelectStream(regSelectStream),
        .bus(bus), .MARVal(MARVal), .IRVal(IRVal), .RZVal(RZVal),
        .LOVal(LOVal), .HIVal(HIVal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic clr();
        reset = 0; GPRin = '0; GPRout = '0;
        PCin = 0; IRin = 0; RYin = 0; RZin = 0; MARin = 0; HIin = 0; LOin = 0;
        MDRin = 0; Read = 0; MDRout = 0; LOout = 0; HIout = 0; Zhighout = 0;
        Zlowout = 0; PCout = 0;
        ADD = 0; SUB = 0; MUL = 0; DIV = 0; SHR = 0; SHL = 0; ROR = 0; ROL = 0;
        AND = 0; OR = 0; NEGATE = 0; NOT = 0; IncPC = 0;
        Mdatain = '0;
    endtask

    // Bit order matches the listed priority: bit0 = IncPC ... bit12 = NOT.
    task automatic set_ops(input logic [12:0] v);
        IncPC = v[0]; ADD = v[1]; SUB = v[2]; MUL = v[3]; DIV = v[4];
        SHR = v[5]; SHL = v[6]; ROR = v[7]; ROL = v[8]; AND = v[9];
        OR = v[10]; NEGATE = v[11]; NOT = v[12];
    endtask

    function automatic logic [63:0] model_bus();
        for (int i = 0; i < NREG; i++) if (GPRout[i]) return m_gpr[i];
        if (PCout)    return m_pc;
        if (MDRout)   return m_mdr;
        if (HIout)    return m_hi;
        if (LOout)    return m_lo;
        if (Zhighout) return m_rz[127:64];
        if (Zlowout)  return m_rz[63:0];
        return 64'd0;
    endfunction

    function automatic logic [127:0] model_alu(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic [63:0] r, ma, mb, q, rm;
        int n;
        n = int'(b[5:0]);
        r = a;
        if (IncPC)       return {64'd0, b + 64'd1};
        else if (ADD)    return {64'd0, a + b};
        else if (SUB)    return {64'd0, a - b};
        else if (MUL) begin
            sa = $signed(a); sb = $signed(b);
            return sa * sb;
        end else if (DIV) begin
`ifdef DATAPATH_DIV_EN
            if (b == 64'd0) return {a, {64{1'b1}}};
            ma = a[63] ? -a : a;
            mb = b[63] ? -b : b;
            q  = ma / mb;
            rm = ma % mb;
            if (a[63] != b[63]) q = -q;
            if (a[63]) rm = -rm;
            return {rm, q};
`else
            ma = 0; mb = 0; q = 0; rm = 0;
            return 128'd0;
`endif
        end
        else if (SHR)    return {64'd0, a >> n};
        else if (SHL)    return {64'd0, a << n};
        else if (ROR) begin
            for (int k = 0; k < n; k++) r = {r[0], r[63:1]};
            return {64'd0, r};
        end else if (ROL) begin
            for (int k = 0; k < n; k++) r = {r[62:0], r[63]};
            return {64'd0, r};
        end
        else if (AND)    return {64'd0, a & b};
        else if (OR)     return {64'd0, a | b};
        else if (NEGATE) return {64'd0, 64'd0 - b};
        else if (NOT)    return {64'd0, ~b};
        return 128'd0;
    endfunction

    function automatic logic [BITS*TOT-1:0] model_stream();
        logic [BITS*TOT-1:0] s;
        s = '0;
        for (int i = 0; i < NREG; i++) s[i*64 +: 64] = m_gpr[i];
        s[(NREG+0)*64 +: 64] = m_pc;
        s[(NREG+1)*64 +: 64] = m_ir;
        s[(NREG+2)*64 +: 64] = m_ry;
        s[(NREG+3)*64 +: 64] = m_mar;
        s[(NREG+4)*64 +: 64] = m_hi;
        s[(NREG+5)*64 +: 64] = m_lo;
        s[(NREG+6)*64 +: 64] = m_mdr;
        return s;
    endfunction

    function automatic int first_diff_slot(input logic [BITS*TOT-1:0] x, input logic [BITS*TOT-1:0] y);
        for (int k = 0; k < TOT; k++) if (x[k*64 +: 64] !== y[k*64 +: 64]) return k;
        return -1;
    endfunction

    // Apply current inputs for one clock to both DUT and model; returns #1 after the edge.
    task automatic step();
        logic [63:0]  mb;
        logic [127:0] res;
        mb  = model_bus();
        res = model_alu(m_ry, mb);
        @(posedge Clock);
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_gpr[i] = '0;
            m_pc = 0; m_ir = 0; m_ry = 0; m_mar = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_rz = 0;
        end else begin
            for (int i = 0; i < NREG; i++) if (GPRin[i]) m_gpr[i] = mb;
            if (PCin)  m_pc  = mb;
            if (IRin)  m_ir  = mb;
            if (RYin)  m_ry  = mb;
            if (MARin) m_mar = mb;
            if (HIin)  m_hi  = mb;
            if (LOin)  m_lo  = mb;
            if (MDRin) m_mdr = Read ? Mdatain : mb;
            if (RZin)  m_rz  = res;
        end
        #1;
    endtask

    task automatic do_reset();
        clr(); reset = 1; step(); clr();
    endtask

    task automatic load_mdr(input logic [63:0] v);
        clr(); Read = 1; MDRin = 1; Mdatain = v; step(); clr();
    endtask

    task automatic set_ry(input logic [63:0] v);
        load_mdr(v); MDRout = 1; RYin = 1; step(); clr();
    endtask

    task automatic alu_from_mdr(input logic [63:0] bval, input logic [12:0] ops);
        load_mdr(bval); MDRout = 1; RZin = 1; set_ops(ops); step(); clr();
    endtask

    task automatic test_reset();
        logic [BITS*TOT-1:0] zero_s;
        zero_s = '0;
        do_reset();
        checks++;
        if (regSelectStream !== zero_s) begin
            errors++;
            $display("FAIL reset_stream slot %0d nonzero", first_diff_slot(regSelectStream, zero_s));
        end
        checks++;
        if (RZVal !== 128'd0) begin errors++; $display("FAIL reset_rz got %h exp 0", RZVal); end
        checks++;
        if ({MARVal, IRVal, LOVal, HIVal} !== 256'd0) begin
            errors++; $display("FAIL reset_vals got %h %h %h %h exp 0", MARVal, IRVal, LOVal, HIVal);
        end
        checks++;
        if (bus !== 64'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", bus); end
    endtask

    task automatic test_mul_program();
        load_mdr(64'h22); MDRout = 1; GPRin[2] = 1; step(); clr();
        load_mdr(64'h24); MDRout = 1; GPRin[4] = 1; step(); clr();
        GPRout[2] = 1; RYin = 1; step(); clr();
        GPRout[4] = 1; MUL = 1; RZin = 1; step(); clr();
        Zlowout = 1; LOin = 1; step(); clr();
        Zhighout = 1; HIin = 1; step(); clr();
        checks++;
        if (LOVal !== 64'h4C8) begin errors++; $display("FAIL mul_lo got %h exp 4c8", LOVal); end
        checks++;
        if (HIVal !== 64'h0) begin errors++; $display("FAIL mul_hi got %h exp 0", HIVal); end
        checks++;
        if (RZVal !== 128'h4C8) begin errors++; $display("FAIL mul_rz got %h exp 4c8", RZVal); end
    endtask

    task automatic test_fetch();
        do_reset();
        PCout = 1; MARin = 1; IncPC = 1; RZin = 1; step(); clr();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 64'h4A920000; step(); clr();
        MDRout = 1; IRin = 1; step(); clr();
        checks++;
        if (MARVal !== 64'd0) begin errors++; $display("FAIL fetch_mar got %h exp 0", MARVal); end
        checks++;
        if (regSelectStream[NREG*64 +: 64] !== 64'd1) begin
            errors++; $display("FAIL fetch_pc got %h exp 1", regSelectStream[NREG*64 +: 64]);
        end
        checks++;
        if (IRVal !== 64'h4A920000) begin errors++; $display("FAIL fetch_ir got %h exp 4a920000", IRVal); end
    endtask

    task automatic test_signed_mul();
        set_ry(-64'sd3);
        alu_from_mdr(64'd5, 13'b1 << 3);
        checks++;
        if (RZVal !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1}) begin
            errors++; $display("FAIL mul_signed got %h exp ffff..fff1", RZVal);
        end
    endtask

    task automatic test_div();
        logic [127:0] e1, e2;
`ifdef DATAPATH_DIV_EN
        e1 = {64'd2, 64'd14};
        e2 = {64'd100, {64{1'b1}}};
`else
        e1 = 128'd0;
        e2 = 128'd0;
`endif
        set_ry(64'd100);
        alu_from_mdr(64'd7, 13'b1 << 4);
        checks++;
        if (RZVal !== e1) begin errors++; $display("FAIL div_7 got %h exp %h", RZVal, e1); end
        alu_from_mdr(64'd0, 13'b1 << 4);
        checks++;
        if (RZVal !== e2) begin errors++; $display("FAIL div_0 got %h exp %h", RZVal, e2); end
    endtask

    task automatic test_shift();
        set_ry(64'd1);
        alu_from_mdr(64'd4, 13'b1 << 6);
        checks++;
        if (RZVal !== 128'h10) begin errors++; $display("FAIL shl got %h exp 10", RZVal); end
        alu_from_mdr(64'd1, 13'b1 << 7);
        checks++;
        if (RZVal !== {64'd0, 64'h8000_0000_0000_0000}) begin
            errors++; $display("FAIL ror got %h exp 8000..0", RZVal);
        end
        clr(); #1;
        checks++;
        if (bus !== 64'd0) begin errors++; $display("FAIL bus_idle got %h exp 0", bus); end
    endtask

    task automatic test_bus_priority();
        logic [63:0] exp_b;
        for (int i = 0; i < NREG; i++) begin
            load_mdr({$urandom(), $urandom()}); MDRout = 1; GPRin[i] = 1; step(); clr();
        end
        load_mdr({$urandom(), $urandom()}); MDRout = 1; PCin = 1; HIin = 1; step(); clr();
        load_mdr({$urandom(), $urandom()}); MDRout = 1; LOin = 1; step(); clr();
        load_mdr({$urandom(), $urandom()});
        for (int t = 0; t < 40; t++) begin
            clr();
            GPRout   = ($urandom_range(0, 2) == 0) ? 16'($urandom()) : 16'd0;
            PCout    = 1'($urandom());
            MDRout   = 1'($urandom());
            HIout    = 1'($urandom());
            LOout    = 1'($urandom());
            Zhighout = 1'($urandom());
            Zlowout  = 1'($urandom());
            #1;
            exp_b = model_bus();
            checks++;
            if (bus !== exp_b) begin errors++; $display("FAIL bus_prio trial %0d got %h exp %h", t, bus, exp_b); end
        end
        clr();
    endtask

    task automatic test_random();
        logic [63:0] ra, rb;
        logic [12:0] ops;
        logic [BITS*TOT-1:0] exp_s;
        int d;
        for (int it = 0; it < 150; it++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 200)) - 64'd100;
            if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 70)) - 64'd35;
            set_ry(ra);
            load_mdr(rb);
            ops = 13'b1 << $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0) ops = ops | (13'b1 << $urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) ops = '0;
            set_ops(ops);
            MDRout = 1; RZin = 1;
            GPRin[$urandom_range(0, NREG - 1)] = 1;
            step(); clr();
            checks++;
            if (RZVal !== m_rz) begin
                errors++; $display("FAIL rz_rand it %0d ops %b got %h exp %h", it, ops, RZVal, m_rz);
            end
            exp_s = model_stream();
            checks++;
            if (regSelectStream !== exp_s) begin
                errors++;
                d = first_diff_slot(regSelectStream, exp_s);
                $display("FAIL stream_rand it %0d slot %0d got %h exp %h", it, d,
                         regSelectStream[d*64 +: 64], exp_s[d*64 +: 64]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [BITS*TOT-1:0] zero_s;
        zero_s = '0;
        load_mdr(64'h22); MDRout = 1; GPRin[2] = 1; step(); clr();
        load_mdr(64'h24); MDRout = 1; GPRin[4] = 1; step(); clr();
        GPRout[2] = 1; RYin = 1; step(); clr();
        checks++;
        if (regSelectStream[(NREG+2)*64 +: 64] !== 64'h22) begin
            errors++; $display("FAIL mid_pre_ry got %h exp 22", regSelectStream[(NREG+2)*64 +: 64]);
        end
        GPRout[4] = 1; MUL = 1; RZin = 1; reset = 1; step(); clr();
        checks++;
        if (RZVal !== 128'd0) begin errors++; $display("FAIL mid_rz got %h exp 0", RZVal); end
        checks++;
        if (regSelectStream !== zero_s) begin
            errors++; $display("FAIL mid_stream slot %0d nonzero", first_diff_slot(regSelectStream, zero_s));
        end
    endtask

    initial begin
        clr();
        for (int i = 0; i < NREG; i++) m_gpr[i] = '0;
        m_pc = 0; m_ir = 0; m_ry = 0; m_mar = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_rz = 0;
        @(negedge Clock);
        test_reset();
        test_mul_program();
        test_fetch();
        test_signed_mul();
        test_div();
        test_shift();
        test_bus_priority();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
